// File: rtl/e203_ifu_ift2icb_mo_pkg.sv
// Shared defaults and helpers for the multi-outstanding IFU fetch-to-ICB bridge.
// Width defaults track the core-wide defines when they are already present.
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif
`ifndef E203_ADDR_SIZE
`define E203_ADDR_SIZE 32
`endif
`ifndef E203_SYSMEM_DATA_WIDTH
`define E203_SYSMEM_DATA_WIDTH 32
`endif

package e203_ifu_ift2icb_mo_pkg;

    localparam int unsigned PC_SIZE_DFLT   = `E203_PC_SIZE;
    localparam int unsigned ADDR_SIZE_DFLT = `E203_ADDR_SIZE;
    localparam int unsigned DW_DFLT        = `E203_SYSMEM_DATA_WIDTH;

    // Whether a bus response belongs to a live fetch or to one killed by a flush.
    typedef enum logic {
        RSP_LIVE = 1'b0,
        RSP_KILL = 1'b1
    } rsp_mode_e;

    // Ring pointer advance for a depth that need not be a power of two.
    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/e203_ifu_rsp_clrbuf.sv
// One-entry bypass buffer with synchronous clear; passes data straight through while empty
// and holds one beat when the consumer stalls.

module e203_ifu_rsp_clrbuf #(
    parameter int DW = 65
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_in_vld,
    output logic          o_in_rdy,
    input  logic [DW-1:0] i_in_dat,
    output logic          o_out_vld,
    input  logic          i_out_rdy,
    output logic [DW-1:0] o_out_dat
);

    logic          r_buf_vld;
    logic [DW-1:0] r_buf_dat;
    logic          w_store;
    logic          w_pop;
    logic          w_vld_ld;

    // A clear frees the slot in the same cycle, so the upstream may handshake into the discard.
    assign o_in_rdy  = ~(r_buf_vld & ~i_clr);
    assign o_out_vld = ~i_clr & (r_buf_vld | i_in_vld);
    assign o_out_dat = r_buf_vld ? r_buf_dat : (i_in_vld ? i_in_dat : '0);

    assign w_store  = i_in_vld & ~r_buf_vld & ~i_out_rdy & ~i_clr;
    assign w_pop    = r_buf_vld & i_out_rdy;
    assign w_vld_ld = i_clr | w_store | w_pop;

    sirv_gnrl_dfflr #(.DW(1)) u_buf_vld (
        .lden  (w_vld_ld),
        .dnxt  (w_store),
        .qout  (r_buf_vld),
        .clk   (clk),
        .rst_n (rst_n)
    );

    sirv_gnrl_dffl #(.DW(DW)) u_buf_dat (
        .lden (w_store),
        .dnxt (i_in_dat),
        .qout (r_buf_dat),
        .clk  (clk)
    );

endmodule

// File: rtl/sirv_gnrl_dffs.sv
// General-purpose flop primitives: load-enabled with async reset, and load-enabled without reset.

module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst_n
);

    logic [DW-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (lden) begin
            r_q <= dnxt;
        end
    end

    assign qout = r_q;

endmodule

module sirv_gnrl_dffl #(
    parameter int DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk
);

    logic [DW-1:0] r_q;

    // NOTE: storage with a separate valid qualifier needs no reset; content is never read while invalid.
    always_ff @(posedge clk) begin
        if (lden) begin
            r_q <= dnxt;
        end
    end

    assign qout = r_q;

endmodule

// File: rtl/e203_ifu_ift2icb_mo.sv
// Multi-outstanding IFU fetch-to-ICB bridge: up to OUTS commands in flight, in-order responses
// tagged with their PC, and flush-time discard of every response still owed.

module e203_ifu_ift2icb_mo
    import e203_ifu_ift2icb_mo_pkg::*;
#(
    parameter int PC_SIZE   = PC_SIZE_DFLT,
    parameter int ADDR_SIZE = ADDR_SIZE_DFLT,
    parameter int DW        = DW_DFLT,
    parameter int INSTR_W   = 32,
    parameter int OUTS      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ifu_flush,
    input  logic                 ifu_req_valid,
    output logic                 ifu_req_ready,
    input  logic [PC_SIZE-1:0]   ifu_req_pc,
    output logic                 ifu_rsp_valid,
    input  logic                 ifu_rsp_ready,
    output logic                 ifu_rsp_err,
    output logic [INSTR_W-1:0]   ifu_rsp_instr,
    output logic [PC_SIZE-1:0]   ifu_rsp_pc,
    output logic                 ifu2biu_icb_cmd_valid,
    input  logic                 ifu2biu_icb_cmd_ready,
    output logic [ADDR_SIZE-1:0] ifu2biu_icb_cmd_addr,
    input  logic                 ifu2biu_icb_rsp_valid,
    output logic                 ifu2biu_icb_rsp_ready,
    input  logic                 ifu2biu_icb_rsp_err,
    input  logic [DW-1:0]        ifu2biu_icb_rsp_rdata
);

    localparam int CNT_W = $clog2(OUTS + 1);
    localparam int PTR_W = (OUTS > 1) ? $clog2(OUTS) : 1;
    localparam int BUF_W = 1 + PC_SIZE + INSTR_W;

    logic [CNT_W-1:0]   r_out_cnt;
    logic [CNT_W-1:0]   r_kill_cnt;
    logic [CNT_W-1:0]   w_out_cnt_nxt;
    logic [CNT_W-1:0]   w_kill_cnt_nxt;
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W-1:0]   w_wptr_nxt;
    logic [PTR_W-1:0]   w_rptr_nxt;
    logic [PC_SIZE-1:0] r_pc_fifo [OUTS];
    logic [PC_SIZE-1:0] w_head_pc;

    logic               w_can_issue;
    logic               w_cmd_hsk;
    logic               w_rsp_hsk;
    logic               w_out_inc;
    logic               w_out_dec;
    logic               w_out_ld;
    logic               w_kill_ld;
    rsp_mode_e          w_mode;

    logic               w_buf_in_vld;
    logic               w_buf_in_rdy;
    logic [BUF_W-1:0]   w_buf_in_dat;
    logic [BUF_W-1:0]   w_buf_out_dat;

    // The outstanding limit is a registered compare, so a same-cycle response cannot reopen issue.
    assign w_can_issue           = (r_out_cnt < CNT_W'(OUTS)) & ~ifu_flush;
    assign ifu2biu_icb_cmd_valid = ifu_req_valid & w_can_issue;
    assign ifu_req_ready         = ifu2biu_icb_cmd_ready & w_can_issue;
    assign ifu2biu_icb_cmd_addr  = ifu_req_pc[ADDR_SIZE-1:0];
    assign w_cmd_hsk             = ifu2biu_icb_cmd_valid & ifu2biu_icb_cmd_ready;

    assign w_mode                = (r_kill_cnt != '0) ? RSP_KILL : RSP_LIVE;
    assign ifu2biu_icb_rsp_ready = (w_mode == RSP_KILL) | w_buf_in_rdy;
    assign w_rsp_hsk             = ifu2biu_icb_rsp_valid & ifu2biu_icb_rsp_ready;

    // PC FIFO: written on command handshake, popped on every bus response, killed or live.
    for (genvar g = 0; g < OUTS; g++) begin : g_pc_fifo
        sirv_gnrl_dffl #(.DW(PC_SIZE)) u_pc (
            .lden (w_cmd_hsk & (r_wptr == PTR_W'(g))),
            .dnxt (ifu_req_pc),
            .qout (r_pc_fifo[g]),
            .clk  (clk)
        );
    end

    assign w_head_pc  = r_pc_fifo[r_rptr];
    assign w_wptr_nxt = PTR_W'(ptr_wrap_inc(32'(r_wptr), OUTS));
    assign w_rptr_nxt = PTR_W'(ptr_wrap_inc(32'(r_rptr), OUTS));

    sirv_gnrl_dfflr #(.DW(PTR_W)) u_wptr (
        .lden  (w_cmd_hsk),
        .dnxt  (w_wptr_nxt),
        .qout  (r_wptr),
        .clk   (clk),
        .rst_n (rst_n)
    );

    sirv_gnrl_dfflr #(.DW(PTR_W)) u_rptr (
        .lden  (w_rsp_hsk),
        .dnxt  (w_rptr_nxt),
        .qout  (r_rptr),
        .clk   (clk),
        .rst_n (rst_n)
    );

    assign w_out_inc     = w_cmd_hsk & ~w_rsp_hsk;
    assign w_out_dec     = w_rsp_hsk & ~w_cmd_hsk;
    assign w_out_ld      = w_out_inc | w_out_dec;
    assign w_out_cnt_nxt = w_out_inc ? (r_out_cnt + CNT_W'(1)) : (r_out_cnt - CNT_W'(1));

    sirv_gnrl_dfflr #(.DW(CNT_W)) u_out_cnt (
        .lden  (w_out_ld),
        .dnxt  (w_out_cnt_nxt),
        .qout  (r_out_cnt),
        .clk   (clk),
        .rst_n (rst_n)
    );

    // A flush owes a discard for everything in flight except a response leaving this very cycle.
    always_comb begin
        // NOTE: combinational blocks use blocking assignment with every output defaulted first, so no latch is inferred.
        w_kill_ld      = 1'b0;
        w_kill_cnt_nxt = r_kill_cnt;
        if (ifu_flush) begin
            w_kill_ld      = 1'b1;
            w_kill_cnt_nxt = (w_rsp_hsk && (r_out_cnt != '0)) ? (r_out_cnt - CNT_W'(1)) : r_out_cnt;
        end else if (w_rsp_hsk && (w_mode == RSP_KILL)) begin
            w_kill_ld      = 1'b1;
            w_kill_cnt_nxt = r_kill_cnt - CNT_W'(1);
        end
    end

    sirv_gnrl_dfflr #(.DW(CNT_W)) u_kill_cnt (
        .lden  (w_kill_ld),
        .dnxt  (w_kill_cnt_nxt),
        .qout  (r_kill_cnt),
        .clk   (clk),
        .rst_n (rst_n)
    );

    assign w_buf_in_vld = ifu2biu_icb_rsp_valid & (w_mode == RSP_LIVE);
    assign w_buf_in_dat = {ifu2biu_icb_rsp_err, w_head_pc, ifu2biu_icb_rsp_rdata[INSTR_W-1:0]};

    e203_ifu_rsp_clrbuf #(.DW(BUF_W)) u_rsp_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (ifu_flush),
        .i_in_vld  (w_buf_in_vld),
        .o_in_rdy  (w_buf_in_rdy),
        .i_in_dat  (w_buf_in_dat),
        .o_out_vld (ifu_rsp_valid),
        .i_out_rdy (ifu_rsp_ready),
        .o_out_dat (w_buf_out_dat)
    );

    assign {ifu_rsp_err, ifu_rsp_pc, ifu_rsp_instr} = w_buf_out_dat;

endmodule

// File: tb/tb_e203_ifu_ift2icb_mo.sv
// Self-checking bench for e203_ifu_ift2icb_mo (OUTS=2): per-scenario tasks plus a response
// scoreboard that compares every delivered fetch against the expected {err, pc, instr}.

module tb_e203_ifu_ift2icb_mo;

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] instr;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        ifu_flush;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic        ifu_rsp_err;
    logic [31:0] ifu_rsp_instr;
    logic [31:0] ifu_rsp_pc;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;

    int   n_checks = 0;
    int   n_pass   = 0;
    rsp_t sb[$];

    e203_ifu_ift2icb_mo #(
        .PC_SIZE(32), .ADDR_SIZE(32), .DW(32), .INSTR_W(32), .OUTS(2)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ifu_flush             (ifu_flush),
        .ifu_req_valid         (ifu_req_valid),
        .ifu_req_ready         (ifu_req_ready),
        .ifu_req_pc            (ifu_req_pc),
        .ifu_rsp_valid         (ifu_rsp_valid),
        .ifu_rsp_ready         (ifu_rsp_ready),
        .ifu_rsp_err           (ifu_rsp_err),
        .ifu_rsp_instr         (ifu_rsp_instr),
        .ifu_rsp_pc            (ifu_rsp_pc),
        .ifu2biu_icb_cmd_valid (icb_cmd_valid),
        .ifu2biu_icb_cmd_ready (icb_cmd_ready),
        .ifu2biu_icb_cmd_addr  (icb_cmd_addr),
        .ifu2biu_icb_rsp_valid (icb_rsp_valid),
        .ifu2biu_icb_rsp_ready (icb_rsp_ready),
        .ifu2biu_icb_rsp_err   (icb_rsp_err),
        .ifu2biu_icb_rsp_rdata (icb_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every delivered response must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && ifu_rsp_valid && ifu_rsp_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got err=%b pc=%h instr=%h, want no response",
                         ifu_rsp_err, ifu_rsp_pc, ifu_rsp_instr);
            end else begin
                rsp_t exp;
                exp = sb.pop_front();
                if ({ifu_rsp_err, ifu_rsp_pc, ifu_rsp_instr} !== exp)
                    $display("FAIL sb_rsp: got err=%b pc=%h instr=%h, want err=%b pc=%h instr=%h",
                             ifu_rsp_err, ifu_rsp_pc, ifu_rsp_instr, exp.err, exp.pc, exp.instr);
                else
                    n_pass++;
            end
        end
    end

    task automatic go_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic go_sample();
        @(negedge clk);
    endtask

    task automatic bus_rsp(input logic vld, input logic err, input logic [31:0] data);
        icb_rsp_valid = vld;
        icb_rsp_err   = err;
        icb_rsp_rdata = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ifu_flush = 1'b0; ifu_req_valid = 1'b0; ifu_req_pc = '0;
        ifu_rsp_ready = 1'b1; icb_cmd_ready = 1'b0; bus_rsp(1'b0, 1'b0, 32'h0);
        #3;
        n_checks++; if (ifu_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", ifu_rsp_valid); else n_pass++;
        n_checks++; if (icb_rsp_ready !== 1'b1) $display("FAIL reset_icb_rsp_ready: got %b want 1", icb_rsp_ready); else n_pass++;
        n_checks++; if ({ifu_rsp_err, ifu_rsp_pc, ifu_rsp_instr} !== 65'h0)
            $display("FAIL reset_rsp_payload: got err=%b pc=%h instr=%h want all 0", ifu_rsp_err, ifu_rsp_pc, ifu_rsp_instr);
        else n_pass++;
        n_checks++; if (icb_cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b want 0", icb_cmd_valid); else n_pass++;
        go_drive();
        rst_n = 1'b1;
        icb_cmd_ready = 1'b1;
        go_sample();
        n_checks++; if (ifu_req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", ifu_req_ready); else n_pass++;
    endtask

    task automatic test_outstanding_limit();
        go_drive();
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0000;
        go_sample();
        n_checks++; if (ifu_req_ready !== 1'b1) $display("FAIL lim_ready0: got %b want 1", ifu_req_ready); else n_pass++;
        n_checks++; if (icb_cmd_valid !== 1'b1 || icb_cmd_addr !== 32'h8000_0000)
            $display("FAIL lim_cmd0: got valid=%b addr=%h want valid=1 addr=80000000", icb_cmd_valid, icb_cmd_addr);
        else n_pass++;
        go_drive();
        ifu_req_pc = 32'h8000_0004;
        go_sample();
        n_checks++; if (ifu_req_ready !== 1'b1) $display("FAIL lim_ready1: got %b want 1", ifu_req_ready); else n_pass++;
        go_drive();
        ifu_req_pc = 32'h8000_0008;
        go_sample();
        n_checks++; if (ifu_req_ready !== 1'b0) $display("FAIL lim_full_ready: got %b want 0", ifu_req_ready); else n_pass++;
        n_checks++; if (icb_cmd_valid !== 1'b0) $display("FAIL lim_full_cmd_valid: got %b want 0", icb_cmd_valid); else n_pass++;
        go_drive();
        bus_rsp(1'b1, 1'b0, 32'h0000_0013);
        sb.push_back('{err: 1'b0, pc: 32'h8000_0000, instr: 32'h0000_0013});
        go_sample();
        n_checks++; if (ifu_req_ready !== 1'b0) $display("FAIL lim_same_cycle_ready: got %b want 0", ifu_req_ready); else n_pass++;
        n_checks++; if (icb_rsp_ready !== 1'b1) $display("FAIL lim_icb_rsp_ready: got %b want 1", icb_rsp_ready); else n_pass++;
        go_drive();
        bus_rsp(1'b0, 1'b0, 32'h0);
        go_sample();
        n_checks++; if (ifu_req_ready !== 1'b1 || icb_cmd_addr !== 32'h8000_0008)
            $display("FAIL lim_reopen: got ready=%b addr=%h want ready=1 addr=80000008", ifu_req_ready, icb_cmd_addr);
        else n_pass++;
        go_drive();
        ifu_req_valid = 1'b0;
    endtask

    task automatic test_in_order();
        bus_rsp(1'b1, 1'b0, 32'h0010_0093);
        sb.push_back('{err: 1'b0, pc: 32'h8000_0004, instr: 32'h0010_0093});
        go_sample();
        n_checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_pc !== 32'h8000_0004)
            $display("FAIL order_pc1: got valid=%b pc=%h want valid=1 pc=80000004", ifu_rsp_valid, ifu_rsp_pc);
        else n_pass++;
        go_drive();
        bus_rsp(1'b1, 1'b0, 32'h0020_8113);
        sb.push_back('{err: 1'b0, pc: 32'h8000_0008, instr: 32'h0020_8113});
        go_sample();
        go_drive();
        bus_rsp(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_flush_outstanding();
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0010;
        go_drive();
        ifu_req_pc = 32'h8000_0014;
        go_drive();
        ifu_flush = 1'b1; ifu_req_pc = 32'h8000_0020;
        go_sample();
        n_checks++; if (icb_cmd_valid !== 1'b0 || ifu_req_ready !== 1'b0)
            $display("FAIL flush_no_issue: got cmd_valid=%b req_ready=%b want 0 0", icb_cmd_valid, ifu_req_ready);
        else n_pass++;
        go_drive();
        ifu_flush = 1'b0; ifu_req_valid = 1'b0;
        bus_rsp(1'b1, 1'b0, 32'hBAD0_0001);
        go_sample();
        n_checks++; if (icb_rsp_ready !== 1'b1 || ifu_rsp_valid !== 1'b0)
            $display("FAIL flush_kill1: got icb_rdy=%b rsp_valid=%b want 1 0", icb_rsp_ready, ifu_rsp_valid);
        else n_pass++;
        go_drive();
        bus_rsp(1'b1, 1'b0, 32'hBAD0_0002);
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0100;
        go_sample();
        n_checks++; if (icb_rsp_ready !== 1'b1 || ifu_rsp_valid !== 1'b0 || ifu_req_ready !== 1'b1)
            $display("FAIL flush_kill2: got icb_rdy=%b rsp_valid=%b req_rdy=%b want 1 0 1",
                     icb_rsp_ready, ifu_rsp_valid, ifu_req_ready);
        else n_pass++;
        go_drive();
        ifu_req_valid = 1'b0;
        bus_rsp(1'b1, 1'b0, 32'h0000_0297);
        sb.push_back('{err: 1'b0, pc: 32'h8000_0100, instr: 32'h0000_0297});
        go_sample();
        n_checks++; if (ifu_rsp_valid !== 1'b1) $display("FAIL flush_post_valid: got %b want 1", ifu_rsp_valid); else n_pass++;
        go_drive();
        bus_rsp(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_backpressure();
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0200;
        go_drive();
        ifu_req_pc = 32'h8000_0204;
        go_drive();
        ifu_req_valid = 1'b0; ifu_rsp_ready = 1'b0;
        bus_rsp(1'b1, 1'b0, 32'h1111_1111);
        sb.push_back('{err: 1'b0, pc: 32'h8000_0200, instr: 32'h1111_1111});
        go_sample();
        n_checks++; if (icb_rsp_ready !== 1'b1 || ifu_rsp_valid !== 1'b1)
            $display("FAIL bp_first: got icb_rdy=%b rsp_valid=%b want 1 1", icb_rsp_ready, ifu_rsp_valid);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            go_drive();
            bus_rsp(1'b1, 1'b0, 32'h2222_2222);
            go_sample();
            n_checks++; if (icb_rsp_ready !== 1'b0 || ifu_rsp_valid !== 1'b1 || ifu_rsp_pc !== 32'h8000_0200)
                $display("FAIL bp_hold%0d: got icb_rdy=%b rsp_valid=%b pc=%h want 0 1 80000200",
                         i, icb_rsp_ready, ifu_rsp_valid, ifu_rsp_pc);
            else n_pass++;
        end
        go_drive();
        ifu_rsp_ready = 1'b1;
        go_sample();
        n_checks++; if (icb_rsp_ready !== 1'b0) $display("FAIL bp_drain_icb_rdy: got %b want 0", icb_rsp_ready); else n_pass++;
        go_drive();
        sb.push_back('{err: 1'b0, pc: 32'h8000_0204, instr: 32'h2222_2222});
        go_sample();
        n_checks++; if (icb_rsp_ready !== 1'b1 || ifu_rsp_pc !== 32'h8000_0204)
            $display("FAIL bp_second: got icb_rdy=%b pc=%h want 1 80000204", icb_rsp_ready, ifu_rsp_pc);
        else n_pass++;
        go_drive();
        bus_rsp(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_flush_buf_full();
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0300;
        go_drive();
        ifu_req_pc = 32'h8000_0304;
        go_drive();
        ifu_req_valid = 1'b0; ifu_rsp_ready = 1'b0;
        bus_rsp(1'b1, 1'b0, 32'h3333_0300);
        go_drive();
        bus_rsp(1'b0, 1'b0, 32'h0);
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0308;
        go_sample();
        n_checks++; if (ifu_req_ready !== 1'b1 || ifu_rsp_valid !== 1'b1)
            $display("FAIL fbf_setup: got req_rdy=%b rsp_valid=%b want 1 1", ifu_req_ready, ifu_rsp_valid);
        else n_pass++;
        go_drive();
        ifu_req_valid = 1'b0; ifu_flush = 1'b1; ifu_rsp_ready = 1'b1;
        bus_rsp(1'b1, 1'b0, 32'h3333_0304);
        go_sample();
        n_checks++; if (icb_rsp_ready !== 1'b1 || ifu_rsp_valid !== 1'b0)
            $display("FAIL fbf_flush: got icb_rdy=%b rsp_valid=%b want 1 0", icb_rsp_ready, ifu_rsp_valid);
        else n_pass++;
        go_drive();
        ifu_flush = 1'b0;
        bus_rsp(1'b1, 1'b0, 32'h3333_0308);
        go_sample();
        n_checks++; if (icb_rsp_ready !== 1'b1 || ifu_rsp_valid !== 1'b0)
            $display("FAIL fbf_kill: got icb_rdy=%b rsp_valid=%b want 1 0", icb_rsp_ready, ifu_rsp_valid);
        else n_pass++;
        go_drive();
        bus_rsp(1'b0, 1'b0, 32'h0);
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0400;
        go_sample();
        n_checks++; if (ifu_req_ready !== 1'b1) $display("FAIL fbf_reissue: got %b want 1", ifu_req_ready); else n_pass++;
        go_drive();
        ifu_req_valid = 1'b0;
        bus_rsp(1'b1, 1'b0, 32'h0000_0400);
        sb.push_back('{err: 1'b0, pc: 32'h8000_0400, instr: 32'h0000_0400});
        go_sample();
        n_checks++; if (ifu_rsp_valid !== 1'b1) $display("FAIL fbf_live_after: got %b want 1", ifu_rsp_valid); else n_pass++;
        go_drive();
        bus_rsp(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_error_reset();
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0500;
        go_drive();
        ifu_req_valid = 1'b0;
        bus_rsp(1'b1, 1'b1, 32'hDEAD_BEEF);
        sb.push_back('{err: 1'b1, pc: 32'h8000_0500, instr: 32'hDEAD_BEEF});
        go_sample();
        n_checks++; if (ifu_rsp_err !== 1'b1) $display("FAIL err_flag: got %b want 1", ifu_rsp_err); else n_pass++;
        go_drive();
        bus_rsp(1'b0, 1'b0, 32'h0);
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0600;
        go_drive();
        ifu_req_pc = 32'h8000_0604;
        go_drive();
        ifu_req_valid = 1'b0; ifu_rsp_ready = 1'b0;
        bus_rsp(1'b1, 1'b0, 32'h6666_0600);
        go_drive();
        bus_rsp(1'b0, 1'b0, 32'h0);
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0608;
        go_drive();
        ifu_req_valid = 1'b0;
        go_sample();
        n_checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_pc !== 32'h8000_0600 || ifu_req_ready !== 1'b0)
            $display("FAIL rst_pre: got rsp_valid=%b pc=%h req_rdy=%b want 1 80000600 0",
                     ifu_rsp_valid, ifu_rsp_pc, ifu_req_ready);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (ifu_rsp_valid !== 1'b0 || ifu_rsp_pc !== 32'h0)
            $display("FAIL rst_rsp_clear: got rsp_valid=%b pc=%h want 0 0", ifu_rsp_valid, ifu_rsp_pc);
        else n_pass++;
        n_checks++; if (ifu_req_ready !== 1'b1 || icb_rsp_ready !== 1'b1)
            $display("FAIL rst_cnt_clear: got req_rdy=%b icb_rdy=%b want 1 1", ifu_req_ready, icb_rsp_ready);
        else n_pass++;
        go_drive();
        rst_n = 1'b1; ifu_rsp_ready = 1'b1;
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0700;
        go_drive();
        ifu_req_valid = 1'b0;
        bus_rsp(1'b1, 1'b0, 32'h0000_0700);
        sb.push_back('{err: 1'b0, pc: 32'h8000_0700, instr: 32'h0000_0700});
        go_sample();
        go_drive();
        bus_rsp(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_outstanding_limit();
        test_in_order();
        test_flush_outstanding();
        test_backpressure();
        test_flush_buf_full();
        test_error_reset();
        go_sample();
        n_checks++; if (sb.size() != 0) $display("FAIL sb_drained: got %0d pending want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/e203_ifu_ift2icb_mo.md
# e203_ifu_ift2icb_mo

Multi-outstanding fetch-to-ICB bridge for the IFU, successor to the single-outstanding ift2icb converter. It converts IFU fetch requests into system-memory ICB commands and keeps up to `OUTS` commands in flight. It returns responses in order together with the PC that produced them. A flush discards every response still owed for pre-flush commands, including any response already buffered.

## Interface
- `PC_SIZE`, default 32: fetch PC width.
- `ADDR_SIZE`, default 32: ICB address width, at most `PC_SIZE`; the address is `ifu_req_pc[ADDR_SIZE-1:0]`.
- `DW`, default 32: ICB read data width.
- `INSTR_W`, default 32: instruction width, at most `DW`; the instruction is `rdata[INSTR_W-1:0]`.
- `OUTS`, default 2: maximum outstanding commands. Must be 1 or more; need not be a power of two.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ifu_flush` in 1: pulse; kills all outstanding fetches.
- `ifu_req_valid` in 1 / `ifu_req_ready` out 1: request handshake.
- `ifu_req_pc` in PC_SIZE: fetch PC.
- `ifu_rsp_valid` out 1 / `ifu_rsp_ready` in 1: response handshake.
- `ifu_rsp_err` out 1: bus error on this fetch.
- `ifu_rsp_instr` out INSTR_W: fetched instruction.
- `ifu_rsp_pc` out PC_SIZE: PC of the returned fetch.
- `ifu2biu_icb_cmd_valid` out 1 / `ifu2biu_icb_cmd_ready` in 1: ICB command handshake.
- `ifu2biu_icb_cmd_addr` out ADDR_SIZE: command address.
- `ifu2biu_icb_rsp_valid` in 1 / `ifu2biu_icb_rsp_ready` out 1: ICB response handshake.
- `ifu2biu_icb_rsp_err` in 1: response error.
- `ifu2biu_icb_rsp_rdata` in DW: response data.

## Operation
- Define `can_issue = (out_cnt < OUTS) & ~ifu_flush`.
- `ifu2biu_icb_cmd_valid = ifu_req_valid & can_issue`.
- `ifu_req_ready = ifu2biu_icb_cmd_ready & can_issue`.
- The command address passes through combinationally.
- On a command handshake, push `ifu_req_pc` into the PC FIFO (depth `OUTS`).
- Each bus response handshake pops the PC FIFO.
- `out_cnt` range is 0..OUTS. It is +1 on a command handshake and -1 on a bus response handshake; when both happen in the same cycle it is unchanged.
- `kill_cnt` range is 0..OUTS. On `ifu_flush`, it loads `out_cnt` minus 1 if a bus response handshakes that same cycle.
  - Otherwise `kill_cnt` decrements on each bus response handshake while it is nonzero.
  - A flush while `kill_cnt` is already nonzero reloads it with the same formula.
- Killed response (`kill_cnt != 0`):
  - `ifu2biu_icb_rsp_ready = 1`.
  - The response is dropped and never appears on `ifu_rsp_*`.
  - Its PC FIFO entry is popped.
- Live response path, through a 1-entry bypass buffer:
  - Buffer empty: `ifu_rsp_*` is driven combinationally from the bus response plus the FIFO head PC.
  - If `ifu_rsp_ready = 0` while a live bus response is valid, the response is stored.
  - Buffer full: `ifu_rsp_*` is driven from the buffer, and `ifu2biu_icb_rsp_ready = 0`.
  - In live mode, `ifu2biu_icb_rsp_ready = ~buf_vld`.
- `ifu_flush` invalidates the buffer in the same cycle: `ifu_rsp_valid` is forced to 0 that cycle, and the buffer is empty on the next cycle.
- Responses are strictly in order; the bus is required to return responses in order.

## Timing
- Reset values:
  - `out_cnt`, `kill_cnt`, FIFO pointers and `buf_vld` are 0.
  - `ifu_rsp_valid` is 0.
  - `ifu_rsp_err`, `ifu_rsp_instr` and `ifu_rsp_pc` are 0 while the buffer is empty and no bus response is valid.
  - `ifu2biu_icb_rsp_ready` is 1.
- Zero-cycle pass-through command→ICB. Bus response→IFU is zero-cycle when the buffer is empty; otherwise it emerges the cycle after the buffer drains.
- Full: with `out_cnt == OUTS`, `ifu_req_ready = 0` even if `cmd_ready = 1`. A bus response handshake in that cycle does not reopen issue until the next cycle, because the limit is a registered compare.
- Flush cycle: no command is issued and `ifu_rsp_valid = 0`. Issue resumes the next cycle while kills drain in parallel.
- FIFO pointers wrap at `OUTS - 1`, using explicit compare-and-reset, not power-of-two masking.
- Reset mid-operation: all state clears asynchronously. The system is required to reset the BIU together with this block.

## Structure
- Package constants: none are new. Widths come from the existing `E203_PC_SIZE`, `E203_ADDR_SIZE` and `E203_SYSMEM_DATA_WIDTH` defines, mapped to the parameter defaults.
- Sub-module `e203_ifu_rsp_clrbuf`: a 1-entry bypass buffer with a synchronous `clr` input, carrying `{err, pc, instr}`.
- The PC FIFO and counters stay in the top module, built from the `sirv_gnrl_dfflr` primitives.

## Test plan
- Outstanding limit (OUTS=2, `cmd_ready=1`, no responses): requests at 0x80000000 and 0x80000004 are accepted; `ifu_req_ready` is 0 for 0x80000008. After one response, 0x80000008 is issued the following cycle.
- In-order return: responses 0x00000013 then 0x00100093 → `ifu_rsp_pc` shows 0x80000000 then 0x80000004 with matching instructions, `err=0`.
- Flush with 2 outstanding: both bus responses see `rsp_ready=1` and `ifu_rsp_valid` stays 0. A post-flush fetch at 0x80000100 returns its instruction with `pc=0x80000100`.
- Backpressure (`ifu_rsp_ready=0`): the first response is buffered and `icb rsp_ready` drops, so the second response is held on the bus. Releasing `ifu_rsp_ready` delivers both in order on consecutive cycles.
- Flush while the buffer is full and one response handshakes that cycle (2 outstanding): the buffer clears, `kill_cnt=1`, and exactly one further response is dropped.
- Error plus reset: `rsp_err=1` → `ifu_rsp_err=1` with the correct PC. Asserting `rst_n=0` with 2 outstanding clears `out_cnt` and `ifu_rsp_valid` immediately.
